wb_group_arbiter: RTL and testbench

//  Shares one register-file write port (one writeback group) among NUM_UNITS execution units.

---
 rtl/wb_group_arbiter_pkg.sv | 34 +++
 rtl/wb_group_arbiter_rr.sv | 29 ++
 rtl/wb_group_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_group_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_group_arbiter_pkg.sv
// Shared types for the writeback group arbiter.
//   STARVE_CNT_W : width of the per-unit starvation counters
//   wb_packet_t  : one registered writeback (id, phys_addr, data, valid) at default widths
//   starve_next  : next value of one starvation counter
package wb_group_arbiter_pkg;

    localparam int unsigned STARVE_CNT_W = 4;
    localparam int unsigned WB_ID_W      = 3;
    localparam int unsigned WB_ADDR_W    = 6;
    localparam int unsigned WB_DATA_W    = 32;

    typedef struct packed {
        logic [WB_ID_W-1:0]   id;
        logic [WB_ADDR_W-1:0] phys_addr;
        logic [WB_DATA_W-1:0] data;
        logic                 valid;
    } wb_packet_t;

    // Counts cycles a unit has been denied; clears on grant or when the unit is idle.
    function automatic logic [STARVE_CNT_W-1:0] starve_next(
        input logic [STARVE_CNT_W-1:0] cnt,
        input logic                    done,
        input logic                    ack,
        input logic [STARVE_CNT_W-1:0] limit
    );
        if (!done || ack) begin
            return '0;
        end else if (cnt < limit) begin
            return cnt + STARVE_CNT_W'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/wb_group_arbiter_rr.sv
// rr_picker: combinational round-robin pick.
//   req : request vector
//   ptr : index where the search starts (inclusive)
//   gnt : one-hot grant, lowest requester at or above ptr, else lowest requester overall
module rr_picker #(
    parameter int unsigned WIDTH = 3,
    localparam int unsigned PtrW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PtrW-1:0]  ptr,
    output logic [WIDTH-1:0] gnt
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] pick_src;

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (PtrW'(i) >= ptr);
        end
        masked   = req & mask;
        pick_src = (|masked) ? masked : req;
        // Isolate the lowest set bit.
        gnt      = pick_src & (~pick_src + WIDTH'(1));
    end

endmodule

// File: rtl/wb_group_arbiter.sv
// wb_group_arbiter: shares one register-file write port among NUM_UNITS execution units.
// Unit 0 has fixed priority, units 1..N-1 are round-robin, and a starvation override lets a
// long-waiting multicycle unit pre-empt unit 0.
//   clk, rst          : clock, asynchronous active-high reset
//   unit_done         : per-unit result valid (held until ack)
//   unit_id/phys_addr/rd : per-unit packed result fields
//   unit_ack          : combinational one-hot grant
//   wb_valid/id/phys_addr/data : registered writeback, one cycle after the grant
//   starve_event      : registered, set when the last grant came from the override
module wb_group_arbiter
    import wb_group_arbiter_pkg::*;
#(
    parameter int unsigned NUM_UNITS    = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ID_WIDTH     = 3,
    parameter int unsigned PHYS_ADDR_W  = 6,
    parameter int unsigned STARVE_LIMIT = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_UNITS-1:0]             unit_done,
    input  logic [NUM_UNITS*ID_WIDTH-1:0]    unit_id,
    input  logic [NUM_UNITS*PHYS_ADDR_W-1:0] unit_phys_addr,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_rd,
    output logic [NUM_UNITS-1:0]             unit_ack,
    output logic                             wb_valid,
    output logic [ID_WIDTH-1:0]              wb_id,
    output logic [PHYS_ADDR_W-1:0]           wb_phys_addr,
    output logic [DATA_WIDTH-1:0]            wb_data,
    output logic                             starve_event
);

    localparam int unsigned IdxW = $clog2(NUM_UNITS);
    localparam int unsigned RrW  = NUM_UNITS - 1;
    localparam int unsigned PtrW = (RrW > 1) ? $clog2(RrW) : 1;
    localparam logic [STARVE_CNT_W-1:0] Limit = STARVE_CNT_W'(STARVE_LIMIT);

    logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [STARVE_CNT_W-1:0] cnt_q [NUM_UNITS];
    logic [STARVE_CNT_W-1:0] cnt_d [NUM_UNITS];
    logic [NUM_UNITS-1:0]    starve_hit;
    logic [NUM_UNITS-1:0]    ack;
    logic                    override;
    logic [RrW-1:0]          rr_gnt;
    logic [PtrW-1:0]         rr_idx;
    logic [ID_WIDTH-1:0]     sel_id;
    logic [PHYS_ADDR_W-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;

    // rr_ptr is 1-based over units 1..N-1; the picker works on a 0-based slice.
    assign rr_idx = PtrW'(rr_ptr_q - IdxW'(1));

    rr_picker #(
        .WIDTH(RrW)
    ) u_rr_picker (
        .req(unit_done[NUM_UNITS-1:1]),
        .ptr(rr_idx),
        .gnt(rr_gnt)
    );

    always_comb begin
        starve_hit = '0;
        for (int j = 1; j < NUM_UNITS; j++) begin
            starve_hit[j] = unit_done[j] && (cnt_q[j] == Limit);
        end

        ack      = '0;
        override = 1'b0;
        if (rst) begin
            ack = '0;
        end else if (|starve_hit) begin
            override = 1'b1;
            // Descending scan so the lowest saturated index is the one left standing.
            for (int j = NUM_UNITS - 1; j >= 1; j--) begin
                if (starve_hit[j]) begin
                    ack    = '0;
                    ack[j] = 1'b1;
                end
            end
        end else if (unit_done[0]) begin
            ack[0] = 1'b1;
        end else begin
            ack[NUM_UNITS-1:1] = rr_gnt;
        end
    end

    assign unit_ack = ack;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int k = 1; k < NUM_UNITS; k++) begin
            if (ack[k]) begin
                rr_ptr_d = (k == NUM_UNITS - 1) ? IdxW'(1) : IdxW'(k + 1);
            end
        end

        cnt_d[0] = '0;
        for (int j = 1; j < NUM_UNITS; j++) begin
            cnt_d[j] = starve_next(cnt_q[j], unit_done[j], ack[j], Limit);
        end

        // One-hot AND-OR result mux.
        sel_id   = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            sel_id   = sel_id   | ({ID_WIDTH{ack[i]}}    & unit_id[i*ID_WIDTH +: ID_WIDTH]);
            sel_addr = sel_addr | ({PHYS_ADDR_W{ack[i]}} & unit_phys_addr[i*PHYS_ADDR_W +: PHYS_ADDR_W]);
            sel_data = sel_data | ({DATA_WIDTH{ack[i]}}  & unit_rd[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= IdxW'(1);
            for (int j = 0; j < NUM_UNITS; j++) begin
                cnt_q[j] <= '0;
            end
            wb_valid     <= 1'b0;
            wb_id        <= '0;
            wb_phys_addr <= '0;
            wb_data      <= '0;
            starve_event <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            for (int j = 0; j < NUM_UNITS; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
            wb_valid     <= |ack;
            starve_event <= override;
            if (|ack) begin
                wb_id        <= sel_id;
                wb_phys_addr <= sel_addr;
                wb_data      <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_group_arbiter.sv
module tb_wb_group_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    unit_done;
    logic [N*IW-1:0] unit_id;
    logic [N*AW-1:0] unit_phys_addr;
    logic [N*DW-1:0] unit_rd;
    logic [N-1:0]    unit_ack;
    logic            wb_valid;
    logic [IW-1:0]   wb_id;
    logic [AW-1:0]   wb_phys_addr;
    logic [DW-1:0]   wb_data;
    logic            starve_event;

    always #5 clk = ~clk;

    wb_group_arbiter #(
        .NUM_UNITS(N),
        .DATA_WIDTH(DW),
        .ID_WIDTH(IW),
        .PHYS_ADDR_W(AW),
        .STARVE_LIMIT(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .unit_done(unit_done),
        .unit_id(unit_id),
        .unit_phys_addr(unit_phys_addr),
        .unit_rd(unit_rd),
        .unit_ack(unit_ack),
        .wb_valid(wb_valid),
        .wb_id(wb_id),
        .wb_phys_addr(wb_phys_addr),
        .wb_data(wb_data),
        .starve_event(starve_event)
    );

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ovr;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] u_id   [N];
    logic [AW-1:0] u_addr [N];
    logic [DW-1:0] u_data [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One arbitration cycle: drive done, check the grant, queue the expected writeback,
    // then compare the registered output one cycle later.
    task automatic cycle(input logic [N-1:0] d, input int g, input logic ovr, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        unit_done = d;
        #1;
        chk({tag, ".ack"}, 64'(unit_ack), (g < 0) ? 64'd0 : (64'd1 << g));
        e       = '0;
        e.valid = (g >= 0);
        if (g >= 0) begin
            e.id   = u_id[g];
            e.addr = u_addr[g];
            e.data = u_data[g];
        end
        e.ovr = ovr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(got.valid));
        if (got.valid) begin
            chk({tag, ".wb_id"},   64'(wb_id),        64'(got.id));
            chk({tag, ".wb_addr"}, 64'(wb_phys_addr), 64'(got.addr));
            chk({tag, ".wb_data"}, 64'(wb_data),      64'(got.data));
        end
        chk({tag, ".starve"}, 64'(starve_event), 64'(got.ovr));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            u_id[i]   = IW'(i + 3);
            u_addr[i] = AW'(10 + i);
            u_data[i] = 32'h1000_0000 + DW'(i * 32'h0101_0101);
        end
        u_data[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            unit_id[i*IW +: IW]        = u_id[i];
            unit_phys_addr[i*AW +: AW] = u_addr[i];
            unit_rd[i*DW +: DW]        = u_data[i];
        end

        // Reset state
        rst       = 1'b1;
        unit_done = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.wb_valid", 64'(wb_valid),     64'd0);
        chk("rst.starve",   64'(starve_event), 64'd0);
        chk("rst.wb_id",    64'(wb_id),        64'd0);
        chk("rst.wb_addr",  64'(wb_phys_addr), 64'd0);
        chk("rst.wb_data",  64'(wb_data),      64'd0);
        unit_done = '1;
        #1;
        chk("rst.ack", 64'(unit_ack), 64'd0);
        unit_done = '0;
        @(negedge clk);
        rst = 1'b0;

        // Unit 0 priority then round-robin with wrap 3->1
        cycle(4'b1111, 0, 1'b0, "t2.g0");
        cycle(4'b1110, 1, 1'b0, "t2.g1");
        cycle(4'b1110, 2, 1'b0, "t2.g2");
        cycle(4'b1110, 3, 1'b0, "t2.g3");
        cycle(4'b1110, 1, 1'b0, "t2.g1b");
        cycle(4'b1110, 2, 1'b0, "t2.g2b");
        cycle(4'b1110, 3, 1'b0, "t2.g3b");
        cycle(4'b0000, -1, 1'b0, "t2.idle");

        // Single request with the DEADBEEF payload
        cycle(4'b0100, 2, 1'b0, "t1.u2");
        cycle(4'b0000, -1, 1'b0, "t1.idle");

        // Long idle
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0000, -1, 1'b0, "t6.idle");
        end

        // Unit 0 hogs, unit 3 overrides on the 8th cycle
        for (int i = 0; i < 7; i++) begin
            cycle(4'b1001, 0, 1'b0, "t3.alu");
        end
        cycle(4'b1001, 3, 1'b1, "t3.ovr");
        cycle(4'b1001, 0, 1'b0, "t3.cnt_clr");
        cycle(4'b0000, -1, 1'b0, "t3.idle");

        // Units 1 and 2 saturate together
        for (int i = 0; i < 7; i++) begin
            cycle(4'b0111, 0, 1'b0, "t4.alu");
        end
        cycle(4'b0111, 1, 1'b1, "t4.ovr1");
        cycle(4'b0101, 2, 1'b1, "t4.ovr2");
        cycle(4'b0001, 0, 1'b0, "t4.alu_after");
        cycle(4'b0000, -1, 1'b0, "t4.idle");

        // Asynchronous reset mid-burst; counter for unit 3 is partly built up first
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1001, 0, 1'b0, "t5.pre");
        end
        chk("t5.pre_valid", 64'(wb_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5.rst_valid",  64'(wb_valid),     64'd0);
        chk("t5.rst_starve", 64'(starve_event), 64'd0);
        chk("t5.rst_ack",    64'(unit_ack),     64'd0);
        @(posedge clk);
        #1;
        chk("t5.rst_hold", 64'(wb_valid), 64'd0);
        rst = 1'b0;
        cycle(4'b1100, 2, 1'b0, "t5.rr_ptr");
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1001, 0, 1'b0, "t5.alu");
        end
        cycle(4'b1001, 3, 1'b1, "t5.ovr");
        cycle(4'b0000, -1, 1'b0, "t5.idle");

        chk("sb.empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
